// File: rtl/pycpu_bus_ctrl_pkg.sv
// Shared types and helpers for the pycpu external-bus master.
package pycpu_bus_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } bus_state_e;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Bits needed to hold 0..max_val, never less than one.
  function automatic int cnt_w(input int max_val);
    return ($clog2(max_val + 1) < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pycpu_bus_ctrl_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer.
module pycpu_bus_ctrl_arbiter #(
  parameter int N_REQ = 3,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] win_idx,
  output logic             win_valid
);

  int idx;

  always_comb begin
    win_idx   = '0;
    win_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!win_valid && req[idx]) begin
        win_idx   = PTR_W'(idx);
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pycpu_bus_ctrl.sv
// External-bus master: round-robin arbitration of internal requesters, one
// single read/write per grant, wait states, timeout and locked bursts.
module pycpu_bus_ctrl
  import pycpu_bus_ctrl_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int N_REQ       = 3,
  parameter int WAIT_CYCLES = 0,
  parameter int TIMEOUT     = 15
) (
  input  logic                    clk,
  input  logic                    n_rst,
  // Requester k holds i_req[k] (level) with stable addr/rw/wdata until it sees
  // o_done[k]; o_done is a one-cycle pulse and the request is never dropped by us.
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_req_rw,
  input  logic [N_REQ-1:0]        i_req_lock,
  input  logic [N_REQ*ADDR_W-1:0] i_req_addr,
  input  logic [N_REQ*DATA_W-1:0] i_req_wdata,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_done,
  output logic                    o_err,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_rw,
  output logic [ADDR_W-1:0]       o_addr,
  output logic [DATA_W-1:0]       o_data,
  output logic                    o_data_oe,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_ready,
  input  logic                    i_lock,
  output logic                    o_lock_oe,
  output logic [1:0]              dbg_state
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int WC_W  = cnt_w(WAIT_CYCLES);
  localparam int TO_W  = cnt_w(TIMEOUT);

  bus_state_e        state, state_nxt;
  logic [PTR_W-1:0]  ptr, owner, win_idx, sel_idx;
  logic              win_valid, burst, take, timed_out, active;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_rw, err_q;
  logic [WC_W-1:0]   wait_cnt;
  logic [TO_W-1:0]   to_cnt;

  pycpu_bus_ctrl_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req       (i_req),
    .ptr       (ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // A locked owner that still requests keeps the bus without re-arbitration.
  assign burst     = i_req_lock[owner] && i_req[owner];
  assign take      = (state == ST_IDLE && win_valid && !i_lock) || (state == ST_DONE && burst);
  assign sel_idx   = (state == ST_DONE) ? owner : win_idx;
  assign timed_out = !i_ready && (to_cnt == TO_W'(TIMEOUT - 1));
  assign dbg_state = state;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    active    = (state != ST_IDLE);
    o_gnt     = '0;
    o_done    = '0;
    o_err     = 1'b0;
    o_rw      = RW_READ;
    o_addr    = '0;
    o_data    = '0;
    o_data_oe = 1'b0;
    o_lock_oe = active;
    if (active) begin
      o_gnt[owner] = 1'b1;
      o_rw         = lat_rw;
      o_addr       = lat_addr;
      o_data       = (lat_rw == RW_WRITE) ? lat_wdata : '0;
    end
    case (state)
      ST_IDLE: if (take) state_nxt = ST_ADDR;
      ST_ADDR: begin
        o_data_oe = (lat_rw == RW_WRITE);
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        o_data_oe = (lat_rw == RW_WRITE);
        if (wait_cnt == '0 && (i_ready || timed_out)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done[owner] = 1'b1;
        o_err         = err_q;
        state_nxt     = burst ? ST_ADDR : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ptr       <= '0;
      owner     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_rw    <= RW_READ;
      err_q     <= 1'b0;
      wait_cnt  <= '0;
      to_cnt    <= '0;
      o_rdata   <= '0;
    end else begin
      if (take) begin
        owner     <= sel_idx;
        lat_addr  <= i_req_addr[int'(sel_idx)*ADDR_W +: ADDR_W];
        lat_wdata <= i_req_wdata[int'(sel_idx)*DATA_W +: DATA_W];
        lat_rw    <= i_req_rw[sel_idx];
      end
      case (state)
        ST_ADDR: begin
          wait_cnt <= WC_W'(WAIT_CYCLES);
          to_cnt   <= '0;
          err_q    <= 1'b0;
        end
        ST_WAIT: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - 1'b1;
          end else if (i_ready) begin
            if (lat_rw == RW_READ) o_rdata <= i_data;
          end else begin
            to_cnt <= to_cnt + 1'b1;
            if (timed_out) err_q <= 1'b1;
          end
        end
        ST_DONE: if (!burst) ptr <= (owner == PTR_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pycpu_bus_ctrl.sv
// Bench for pycpu_bus_ctrl: directed scenarios plus random transactions,
// checked against a transaction-level model (round-robin pick, latency formula).
module tb_pycpu_bus_ctrl;

  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int N_REQ   = 3;
  localparam int WAITC   = 2;
  localparam int TIMEOUT = 15;

  logic                    clk = 1'b0;
  logic                    n_rst;
  logic [N_REQ-1:0]        i_req, i_req_rw, i_req_lock;
  logic [N_REQ*ADDR_W-1:0] i_req_addr;
  logic [N_REQ*DATA_W-1:0] i_req_wdata;
  logic [N_REQ-1:0]        o_gnt, o_done;
  logic                    o_err, o_rw, o_data_oe, i_ready, i_lock, o_lock_oe;
  logic [DATA_W-1:0]       o_rdata, o_data, i_data;
  logic [ADDR_W-1:0]       o_addr;
  logic [1:0]              dbg_state;

  logic [ADDR_W-1:0] addr_a [N_REQ];
  logic [DATA_W-1:0] wdata_a [N_REQ];
  logic [DATA_W-1:0] cur_data;
  logic [DATA_W-1:0] exp_rdata;
  int                rr_ptr;
  int                checks = 0;
  int                errors = 0;

  pycpu_bus_ctrl #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_REQ(N_REQ),
    .WAIT_CYCLES(WAITC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .i_req(i_req), .i_req_rw(i_req_rw), .i_req_lock(i_req_lock),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_gnt(o_gnt), .o_done(o_done), .o_err(o_err), .o_rdata(o_rdata),
    .o_rw(o_rw), .o_addr(o_addr), .o_data(o_data), .o_data_oe(o_data_oe),
    .i_data(i_data), .i_ready(i_ready), .i_lock(i_lock), .o_lock_oe(o_lock_oe),
    .dbg_state(dbg_state)
  );

  // Clock and packing of the per-requester fields.
  always #5 clk = ~clk;

  always_comb begin
    i_req_addr  = '0;
    i_req_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      i_req_addr[k*ADDR_W +: ADDR_W]  = addr_a[k];
      i_req_wdata[k*DATA_W +: DATA_W] = wdata_a[k];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Model: first requester at or after the pointer wins.
  function automatic int rr_pick(input logic [N_REQ-1:0] m, input int p);
    for (int i = 0; i < N_REQ; i++)
      if (m[(p + i) % N_REQ]) return (p + i) % N_REQ;
    return 0;
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, "_gnt"}, 32'(o_gnt), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_err"}, 32'(o_err), 0);
    chk({tag, "_lock_oe"}, 32'(o_lock_oe), 0);
    chk({tag, "_data_oe"}, 32'(o_data_oe), 0);
    chk({tag, "_addr"}, 32'(o_addr), 0);
    chk({tag, "_rw"}, 32'(o_rw), 0);
    chk({tag, "_data"}, 32'(o_data), 0);
    chk({tag, "_rdata"}, 32'(o_rdata), 32'(exp_rdata));
  endtask

  // Called at the negedge of the cycle whose closing edge starts ADDR (cycle 0).
  // k = index of the first sampling cycle with i_ready high; k>=TIMEOUT never raises it.
  task automatic do_txn(input int who, input int k, input bit drop);
    int                done_c, ready_at;
    bit                exp_err;
    logic [N_REQ-1:0]  oh;
    logic              t_rw;
    logic [ADDR_W-1:0] t_addr;
    logic [DATA_W-1:0] t_wdata, t_data;
    oh       = '0;
    oh[who]  = 1'b1;
    t_rw     = i_req_rw[who];
    t_addr   = addr_a[who];
    t_wdata  = wdata_a[who];
    t_data   = cur_data;
    i_data   = cur_data;
    i_ready  = 1'b0;
    exp_err  = (k >= TIMEOUT);
    done_c   = exp_err ? 2 + WAITC + TIMEOUT : 3 + WAITC + k;
    ready_at = 2 + WAITC + k;
    for (int c = 1; c <= done_c; c++) begin
      @(negedge clk);
      chk("gnt", 32'(o_gnt), 32'(oh));
      chk("lock_oe", 32'(o_lock_oe), 1);
      chk("addr", 32'(o_addr), 32'(t_addr));
      chk("rw", 32'(o_rw), 32'(t_rw));
      chk("data", 32'(o_data), t_rw ? 32'(t_wdata) : 0);
      chk("data_oe", 32'(o_data_oe), 32'(t_rw && (c < done_c)));
      chk("done", 32'(o_done), (c == done_c) ? 32'(oh) : 0);
      if (c == done_c) begin
        chk("err", 32'(o_err), 32'(exp_err));
        if (!t_rw && !exp_err) exp_rdata = t_data;
        chk("rdata", 32'(o_rdata), 32'(exp_rdata));
      end else begin
        chk("err_early", 32'(o_err), 0);
      end
      i_ready = (c >= ready_at) && (c < done_c);
      i_lock  = 1'($urandom_range(0, 1));
      if (drop && c == 2) i_req[who] = 1'b0;
    end
    i_ready = 1'b0;
    i_lock  = 1'b0;
  endtask

  // From the cycle before an IDLE cycle: optional i_lock hold, then one unlocked grant.
  task automatic idle_txn(input logic [N_REQ-1:0] mask, input int k, input int lock_cyc,
                          input bit drop);
    int who;
    @(negedge clk);
    check_idle("idle");
    i_req  = mask;
    i_lock = (lock_cyc > 0);
    for (int j = 0; j < lock_cyc; j++) begin
      @(negedge clk);
      check_idle("locked");
    end
    i_lock = 1'b0;
    who    = rr_pick(mask, rr_ptr);
    do_txn(who, k, drop);
    rr_ptr = (who + 1) % N_REQ;
  endtask

  initial begin
    n_rst      = 1'b0;
    i_req      = '0;
    i_req_rw   = '0;
    i_req_lock = '0;
    i_ready    = 1'b0;
    i_lock     = 1'b0;
    i_data     = '0;
    cur_data   = '0;
    exp_rdata  = '0;
    rr_ptr     = 0;
    for (int r = 0; r < N_REQ; r++) begin
      addr_a[r]  = '0;
      wdata_a[r] = '0;
    end
    repeat (2) @(negedge clk);
    check_idle("reset");
    n_rst = 1'b1;

    // Single read with ready already high.
    addr_a[0] = 16'h1234;
    cur_data  = 16'hBEEF;
    idle_txn(3'b001, 0, 0, 0);

    // Single write through the minimum wait states.
    addr_a[1]   = 16'h4000;
    wdata_a[1]  = 16'h00A5;
    i_req_rw[1] = 1'b1;
    idle_txn(3'b010, 0, 0, 0);

    // All requesting: rotation with one IDLE cycle between grants.
    i_req_rw = 3'b010;
    for (int n = 0; n < 4; n++) begin
      cur_data = 16'($urandom);
      idle_txn(3'b111, n, 0, 0);
    end

    // External lock holds off the grant for 10 cycles.
    i_req_rw = '0;
    idle_txn(3'b001, 1, 10, 0);

    // Locked burst of three by requester 2 while requester 0 waits.
    i_req_lock = 3'b100;
    addr_a[2]  = 16'hA000;
    cur_data   = 16'h1111;
    idle_txn(3'b100, 0, 0, 0);
    i_req      = 3'b101;
    addr_a[2]  = 16'hA002;
    wdata_a[2] = 16'h2222;
    i_req_rw   = 3'b100;
    do_txn(2, 3, 0);
    addr_a[2]  = 16'hA004;
    i_req_rw   = 3'b000;
    cur_data   = 16'h3333;
    do_txn(2, 1, 0);
    i_req_lock = '0;
    i_req      = 3'b001;
    rr_ptr     = 0;
    cur_data   = 16'h4444;
    idle_txn(3'b001, 0, 0, 0);

    // Device never ready: timeout with error, read data unchanged.
    cur_data = 16'hDEAD;
    idle_txn(3'b001, TIMEOUT + 5, 0, 0);

    // Asynchronous reset in the middle of a write's wait states.
    @(negedge clk);
    check_idle("pre_rst");
    i_req_rw[1] = 1'b1;
    wdata_a[1]  = 16'h5A5A;
    i_req       = 3'b010;
    repeat (3) @(negedge clk);
    chk("rst_pre_data_oe", 32'(o_data_oe), 1);
    #2 n_rst = 1'b0;
    #1;
    exp_rdata = '0;
    rr_ptr    = 0;
    chk("rst_data_oe", 32'(o_data_oe), 0);
    chk("rst_lock_oe", 32'(o_lock_oe), 0);
    chk("rst_gnt", 32'(o_gnt), 0);
    chk("rst_addr", 32'(o_addr), 0);
    chk("rst_rdata", 32'(o_rdata), 0);
    i_req = '0;
    @(negedge clk);
    n_rst = 1'b1;

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      int k;
      for (int r = 0; r < N_REQ; r++) begin
        addr_a[r]   = 16'($urandom);
        wdata_a[r]  = 16'($urandom);
        i_req_rw[r] = 1'($urandom_range(0, 1));
      end
      cur_data = 16'($urandom);
      k = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                      : int'($urandom_range(0, 6));
      idle_txn(N_REQ'($urandom_range(1, 7)), k, int'($urandom_range(0, 2)),
               $urandom_range(0, 3) == 0);
    end
    i_req = '0;
    @(negedge clk);
    check_idle("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
